// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : divider_if
//  Description : Request/response bundle between the EXE stage and the
//                iterative 32-bit divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface divider_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    // Pipeline side: issues divides and consumes results
    modport master (
        output a, b, signed_div, start, annul,
        input  result, ready, stall
    );

    // Divider side
    modport slave (
        input  a, b, signed_div, start, annul,
        output result, ready, stall
    );
endinterface
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Multi-cycle 32-bit DIV/DIVU unit. Restoring radix-2, one
//                quotient bit per cycle, result {remainder, quotient} shown
//                for a single cycle in END.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider (
    input logic       clk,
    input logic       rst,
    divider_if.slave  bus
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_divzero = 2'd1;
    localparam logic [1:0] c_on      = 2'd2;
    localparam logic [1:0] c_end     = 2'd3;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_divisor;   // magnitude of the divisor
    logic        r_neg_q;     // negate quotient at the end
    logic        r_neg_r;     // negate remainder at the end
    // [64:32] partial remainder, [31:0] dividend bits shifting out / quotient
    // bits shifting in
    logic [64:0] r_shreg;

    logic        w_accept;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_ready;

    // Start acceptance, operand magnitudes, trial subtraction and final sign fix-up
    always_comb begin
        w_accept = (r_state == c_idle) && bus.start && !bus.annul && !rst;
        w_a_neg  = bus.signed_div && bus.a[31];
        w_b_neg  = bus.signed_div && bus.b[31];
        w_a_mag  = w_a_neg ? (32'd0 - bus.a) : bus.a;
        w_b_mag  = w_b_neg ? (32'd0 - bus.b) : bus.b;
        // Shifted remainder is below 2*divisor, so bit 32 alone flags a borrow
        w_diff   = r_shreg[63:31] - {1'b0, r_divisor};
        w_quot   = r_neg_q ? (32'd0 - r_shreg[31:0])  : r_shreg[31:0];
        w_rem    = r_neg_r ? (32'd0 - r_shreg[63:32]) : r_shreg[63:32];
        w_ready  = (r_state == c_end) && !bus.annul && !rst;
    end

    // Output drive: result only visible while ready, stall covers the whole busy window
    always_comb begin
        bus.ready  = w_ready;
        bus.result = w_ready ? {w_rem, w_quot} : 64'h0;
        bus.stall  = !rst && (w_accept || (r_state == c_divzero) || (r_state == c_on));
    end

    // FSM, operand latch and one restoring step per ON cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_cnt     <= 5'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_shreg   <= 65'd0;
        end else if (bus.annul && (r_state != c_idle)) begin
            r_state <= c_idle;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_cnt <= 5'd0;
                        if (bus.b == 32'd0) begin
                            // Zero result: clear everything so END presents 64'h0
                            r_state   <= c_divzero;
                            r_divisor <= 32'd0;
                            r_neg_q   <= 1'b0;
                            r_neg_r   <= 1'b0;
                            r_shreg   <= 65'd0;
                        end else begin
                            r_state   <= c_on;
                            r_divisor <= w_b_mag;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_shreg   <= {33'd0, w_a_mag};
                        end
                    end
                end
                c_divzero: begin
                    r_state <= c_end;
                end
                c_on: begin
                    if (!w_diff[32]) begin
                        r_shreg <= {w_diff, r_shreg[30:0], 1'b1};
                    end else begin
                        r_shreg <= {r_shreg[63:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= c_end;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // The partial remainder always stays below the divisor, so the top bit is never set
    a_rem_fits: assert property (@(posedge clk) disable iff (rst) !r_shreg[64]);

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider
//  Description : Self-checking bench for divider: directed vectors, annul,
//                reset, start collisions and randomized operands against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divider_if dif ();

    divider dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [65:0] c_quiet = 66'h0;
    localparam logic [65:0] c_busy  = {2'b01, 64'h0};

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got ready/stall/result=%h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [65:0] outs();
        return {dif.ready, dif.stall, dif.result};
    endfunction

    // Reference: integer division on magnitudes, then sign rules
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'h0;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[31] != b[31])) q = -q;
        if (s && a[31])            r = -r;
        return {r, q};
    endfunction

    task automatic scramble();
        dif.a          = $urandom;
        dif.b          = $urandom;
        dif.signed_div = 1'($urandom);
    endtask

    // Issue one divide, check every cycle through the following idle cycle
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp);
        int lat;
        lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        dif.a = a; dif.b = b; dif.signed_div = s; dif.start = 1'b1; dif.annul = 1'b0;
        #1 check("accept", outs(), c_busy);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            dif.start = 1'b0;
            scramble();
            #1;
            if (k < lat) check("busy", outs(), c_busy);
            else         check("done", outs(), {2'b10, exp});
        end
        @(negedge clk);
        #1 check("idle_after", outs(), c_quiet);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        rst = 1'b1;
        dif.a = 32'd100; dif.b = 32'd7; dif.signed_div = 1'b0;
        dif.start = 1'b1; dif.annul = 1'b0;

        // Reset with start requested: everything quiet
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check("in_reset", outs(), c_quiet);
        end
        @(negedge clk);
        rst = 1'b0; dif.start = 1'b0;
        #1 check("post_reset", outs(), c_quiet);

        // Directed vectors
        run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000});
        run_div(32'd5, 32'd0, 1'b0, 64'h0);
        run_div(32'h80000000, 32'd0, 1'b1, 64'h0);

        // Annul in ON at T+10, new divide at T+12 finishes at T+45
        @(negedge clk);
        dif.a = 32'd100; dif.b = 32'd7; dif.signed_div = 1'b0; dif.start = 1'b1;
        #1 check("annul_accept", outs(), c_busy);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            dif.start = 1'b0;
            dif.annul = (k == 10);
            #1;
            if (k <= 10) check("annul_busy", outs(), c_busy);
            else         check("annul_idle", outs(), c_quiet);
        end
        dif.annul = 1'b0;
        run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Annul in END suppresses the result
        @(negedge clk);
        dif.a = 32'd1000; dif.b = 32'd3; dif.signed_div = 1'b0; dif.start = 1'b1;
        #1 check("end_annul_accept", outs(), c_busy);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            dif.start = 1'b0;
            dif.annul = (k == 33);
            #1;
            if (k <= 32) check("end_annul_busy", outs(), c_busy);
            else         check("end_annul_quiet", outs(), c_quiet);
        end
        dif.annul = 1'b0;

        // start and annul together in IDLE: never accepted
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dif.start = 1'b1; dif.annul = 1'b1;
            #1 check("start_annul", outs(), c_quiet);
        end
        @(negedge clk);
        dif.start = 1'b0; dif.annul = 1'b0;
        #1 check("start_annul_after", outs(), c_quiet);

        // start held T..T+40: results at T+33 and T+67, second accept at T+34
        @(negedge clk);
        dif.a = 32'd100; dif.b = 32'd7; dif.signed_div = 1'b0; dif.start = 1'b1;
        #1 check("held_accept", outs(), c_busy);
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            dif.start = (k <= 40);
            #1;
            if (k == 33 || k == 67) check("held_done", outs(), {2'b10, 32'd2, 32'd14});
            else if (k == 68)       check("held_idle", outs(), c_quiet);
            else                    check("held_busy", outs(), c_busy);
        end

        // Reset mid-divide at T+20 discards it
        @(negedge clk);
        dif.a = 32'd100; dif.b = 32'd7; dif.signed_div = 1'b0; dif.start = 1'b1;
        #1 check("rst_accept", outs(), c_busy);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            dif.start = 1'b0;
            rst = (k == 20);
            #1;
            if (k < 20) check("rst_busy", outs(), c_busy);
            else        check("rst_quiet", outs(), c_quiet);
        end
        rst = 1'b0;
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF});

        // Randomized operands with corner-case divisors and dividends
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                4: rb = rb >> $urandom_range(1, 31);
                default: ;
            endcase
            run_div(ra, rb, rs, model(ra, rb, rs));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
